// File: rtl/wb_uart.sv
// Wishbone UART: TX FIFO, programmable bit divisor, level interrupt.
// Define WB_UART_RX_EN to include the receiver with a 1-byte holding register.
module wb_uart #(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [1:0]  wb_adr_i,
    input  logic [1:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        uart_tx_o,
    input  logic        uart_rx_i,
    output logic        irq_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [1:0] TX_IDLE = 2'd0, TX_START = 2'd1, TX_DATA = 2'd2, TX_STOP = 2'd3;

    logic        ack_q, irq_q, tx_ov_q;
    logic [31:0] dat_q, rdata;
    logic [15:0] div_q, div_eff;
    logic [1:0]  ien_q;
    logic        access, wr, rd, data_wr, st_wr, push, pop, fifo_empty, fifo_full, tx_empty;
    logic        rx_valid, rx_ov, rx_ferr;
    logic [7:0]  rx_data;
    logic        hi_unused;

    assign access  = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr      = access & wb_we_i & (wb_sel_i != 2'b00);
    assign rd      = access & ~wb_we_i;
    assign data_wr = wr & (wb_adr_i == 2'd0);
    assign st_wr   = wr & (wb_adr_i == 2'd1);
    assign div_eff = (div_q == 16'd0) ? 16'd1 : div_q;
    assign hi_unused = ^wb_dat_i[31:16];

    // TX FIFO; the extra pointer bit distinguishes full from empty
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wptr_q, rptr_q;

    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    // a pop in the same cycle frees the slot, so a push to a full FIFO still lands
    assign push       = data_wr & (~fifo_full | pop);

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= wb_dat_i[7:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // TX FSM
    logic [1:0]  tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_q, tx_d, bit_end;

    assign bit_end  = (tx_cnt_q == 16'd0);
    assign pop      = ~fifo_empty & ((tx_state_q == TX_IDLE) | ((tx_state_q == TX_STOP) & bit_end));
    assign tx_empty = fifo_empty & (tx_state_q == TX_IDLE);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q - 16'd1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        if (tx_state_q == TX_IDLE) tx_cnt_d = tx_cnt_q;
        if (bit_end || tx_state_q == TX_IDLE) begin
            tx_cnt_d = div_eff - 16'd1;
            case (tx_state_q)
                TX_START: begin
                    tx_state_d = TX_DATA;
                    tx_bit_d   = 3'd0;
                    tx_d       = tx_shift_q[0];
                    tx_shift_d = tx_shift_q >> 1;
                end
                TX_DATA: begin
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_d       = tx_shift_q[0];
                        tx_shift_d = tx_shift_q >> 1;
                    end
                end
                default: begin
                    tx_state_d = TX_IDLE;
                    tx_d       = 1'b1;
                end
            endcase
            if (pop) begin
                tx_state_d = TX_START;
                tx_shift_d = mem_q[rptr_q[AW-1:0]];
                tx_d       = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
        end
    end

`ifdef WB_UART_RX_EN
    localparam logic [1:0] RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3;
    logic        rx_meta_q, rx_sync_q, rx_prev_q, rx_valid_q, rx_ov_q, rx_ferr_q, rx_done, rx_rd;
    logic [1:0]  rx_state_q;
    logic [15:0] rx_cnt_q, rx_half;
    logic [2:0]  rx_bit_q;
    logic [7:0]  rx_shift_q, rx_data_q;

    assign rx_half = (div_eff[15:1] == 15'd0) ? 16'd0 : {1'b0, div_eff[15:1]} - 16'd1;
    assign rx_done = (rx_state_q == RX_STOP) && (rx_cnt_q == 16'd0);
    assign rx_rd   = rd & (wb_adr_i == 2'd0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ov_q    <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_meta_q <= uart_rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            rx_cnt_q  <= rx_cnt_q - 16'd1;
            case (rx_state_q)
                RX_IDLE: begin
                    rx_cnt_q <= rx_half;
                    if (rx_prev_q && !rx_sync_q) rx_state_q <= RX_START;
                end
                RX_START: if (rx_cnt_q == 16'd0) begin
                    rx_cnt_q   <= div_eff - 16'd1;
                    rx_bit_q   <= 3'd0;
                    rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (rx_cnt_q == 16'd0) begin
                    rx_cnt_q   <= div_eff - 16'd1;
                    rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_q   <= rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                end
                default: if (rx_done) rx_state_q <= RX_IDLE;
            endcase
            if (rx_done) rx_data_q <= rx_shift_q;
            rx_valid_q <= rx_done | (rx_valid_q & ~rx_rd);
            rx_ov_q    <= (rx_done & rx_valid_q) | (rx_ov_q & ~(st_wr & wb_dat_i[4]));
            rx_ferr_q  <= (rx_done & ~rx_sync_q) | (rx_ferr_q & ~(st_wr & wb_dat_i[5]));
        end
    end

    assign rx_valid = rx_valid_q;
    assign rx_ov    = rx_ov_q;
    assign rx_ferr  = rx_ferr_q;
    assign rx_data  = rx_data_q;
`else
    logic rx_unused;
    assign rx_unused = ^{uart_rx_i, wb_dat_i[5:4]};
    assign rx_valid  = 1'b0;
    assign rx_ov     = 1'b0;
    assign rx_ferr   = 1'b0;
    assign rx_data   = 8'd0;
`endif

    always_comb begin
        rdata = '0;
        case (wb_adr_i)
            2'd0:    rdata = {24'd0, rx_data};
            2'd1:    rdata = {26'd0, rx_ferr, rx_ov, tx_ov_q, rx_valid, tx_empty, fifo_full};
            2'd2:    rdata = {16'd0, div_q};
            default: rdata = {30'd0, ien_q};
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q   <= 1'b0;
            dat_q   <= '0;
            irq_q   <= 1'b0;
            div_q   <= DIV_RESET;
            ien_q   <= '0;
            tx_ov_q <= 1'b0;
        end else begin
            ack_q   <= access;
            dat_q   <= rd ? rdata : '0;
            irq_q   <= (tx_empty & ien_q[0]) | (rx_valid & ien_q[1]);
            tx_ov_q <= (data_wr & fifo_full & ~pop) | (tx_ov_q & ~(st_wr & wb_dat_i[3]));
            if (wr && wb_adr_i == 2'd2) div_q <= wb_dat_i[15:0];
            if (wr && wb_adr_i == 2'd3) ien_q <= wb_dat_i[1:0];
        end
    end

    assign wb_ack_o  = ack_q;
    assign wb_dat_o  = dat_q;
    assign irq_o     = irq_q;
    assign uart_tx_o = tx_q;
endmodule

// File: tb/tb_wb_uart.sv
// Scoreboard bench for wb_uart: bus reads and serial frames are checked by
// independent monitors against expectations queued when stimulus is issued.
module tb_wb_uart;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst, cyc, stb, we, rx;
    logic [1:0]  adr, sel;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack, tx, irq;

    always #5 clk = ~clk;

    wb_uart #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16'd434)) dut (
        .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat_i), .wb_dat_o(dat_o),
        .wb_ack_o(ack), .uart_tx_o(tx), .uart_rx_i(rx), .irq_o(irq)
    );

    int compared = 0, mismatched = 0;
    logic [32:0] rd_q[$];   // {is_read, expected data} per bus cycle
    logic [7:0]  txq[$];    // bytes expected on uart_tx_o, in order
    int          tb_div = 434;
    logic        frame_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // bus monitor
    always @(negedge clk) begin
        logic [32:0] e;
        if (ack === 1'b1) begin
            if (rd_q.size() == 0) check("unexpected_ack", 32'd1, 32'd0);
            else begin
                e = rd_q.pop_front();
                if (e[32]) check("rdata", dat_o, e[31:0]);
            end
        end
    end

    // serial monitor: compares every clock of a frame against the ideal waveform
    initial begin
        logic [7:0] b;
        int d, errs, k;
        logic aborted, expbit;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && tx === 1'b0) begin
                frame_busy = 1'b1;
                if (txq.size() == 0) begin
                    check("unexpected_frame", 32'd1, 32'd0);
                    b = 8'hxx;
                end else b = txq.pop_front();
                d = tb_div; errs = 0; aborted = 1'b0;
                for (int i = 0; i < 10 * d; i++) begin
                    if (i > 0) @(negedge clk);
                    if (rst) begin aborted = 1'b1; break; end
                    k = i / d;
                    expbit = (k == 0) ? 1'b0 : (k <= 8) ? b[k-1] : 1'b1;
                    if (tx !== expbit) errs++;
                end
                if (!aborted) check($sformatf("tx_frame_%02h_bad_clocks", b), errs, 0);
                frame_busy = 1'b0;
            end
        end
    end

    task automatic wb_cycle(input logic w, input logic [1:0] a, input logic [31:0] d,
                            input logic [1:0] s, input logic [31:0] exp);
        int n;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        rd_q.push_back({~w, exp});
        n = 0;
        do begin @(negedge clk); n++; end while (ack !== 1'b1 && n < 8);
        if (ack !== 1'b1) check("ack_timeout", 32'd0, 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
        wb_cycle(1'b1, a, d, 2'b11, 32'd0);
    endtask

    task automatic wb_read(input logic [1:0] a, input logic [31:0] exp);
        wb_cycle(1'b0, a, 32'd0, 2'b11, exp);
    endtask

    task automatic set_div(input int d);
        logic [31:0] r;
        r = $urandom;
        wb_write(2'd2, {r[31:16], 16'(d)});
        tb_div = (d == 0) ? 1 : d;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic expect_sent);
        logic [31:0] r;
        r = $urandom;
        wb_write(2'd0, {r[31:8], b});
        if (expect_sent) txq.push_back(b);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((txq.size() != 0 || frame_busy) && n < budget) begin @(negedge clk); n++; end
        if (n >= budget) check("idle_timeout", 32'd0, 32'd1);
        repeat (3) @(negedge clk);
    endtask

`ifdef WB_UART_RX_EN
    task automatic send_rx(input logic [7:0] b, input logic stop, input int d);
        rx = 1'b0; repeat (d) @(negedge clk);
        for (int i = 0; i < 8; i++) begin rx = b[i]; repeat (d) @(negedge clk); end
        rx = stop; repeat (d) @(negedge clk);
        rx = 1'b1; repeat (2 * d) @(negedge clk);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  ackpat;
        logic [31:0] r;
        logic [7:0]  b1, b2;
        int n, lows;
        cyc = 0; stb = 0; we = 0; adr = 0; sel = 0; dat_i = 0; rx = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1); check("rst_ack", ack, 0);
        check("rst_dat", dat_o, 0); check("rst_irq", irq, 0);
        rst = 1'b0;

        wb_read(2'd1, 32'h02); wb_read(2'd2, 32'd434);
        wb_read(2'd3, 32'd0);  wb_read(2'd0, 32'd0);

        // stb held four cycles: acks in cycles 2 and 4 only
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 2'd2;
        rd_q.push_back({1'b1, 32'd434}); rd_q.push_back({1'b1, 32'd434});
        for (int i = 3; i >= 0; i--) begin @(negedge clk); ackpat[i] = ack; end
        cyc = 1'b0; stb = 1'b0;
        check("ack_hold_pattern", {28'd0, ackpat}, 32'hA);

        wb_cycle(1'b1, 2'd2, 32'h1234, 2'b00, 32'd0);
        wb_read(2'd2, 32'd434);

        set_div(4);
        send_byte(8'hA5, 1'b1);
        wait_idle(200);
        wb_read(2'd1, 32'h02);

        for (int round = 0; round < 5; round++) begin
            n = (round == 0) ? 0 : $urandom_range(1, 7);
            set_div(n);
            wb_read(2'd2, 32'(n));
            for (int j = $urandom_range(1, 5); j > 0; j--) begin
                r = $urandom;
                send_byte(r[7:0], 1'b1);
            end
            wait_idle(2000);
            wb_read(2'd1, 32'h02);
        end

        r = $urandom;
        wb_write(2'd3, r);
        wb_read(2'd3, {30'd0, r[1:0]});

        // interrupt on tx_empty
        set_div(4);
        wb_write(2'd3, 32'd1);
        repeat (3) @(negedge clk);
        check("irq_idle", irq, 1);
        send_byte(8'h5A, 1'b1);
        repeat (2) @(negedge clk);
        check("irq_drop", irq, 0);
        n = 2;
        while (irq !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        check("irq_reassert_window", 32'(n >= 40 && n <= 44), 32'd1);
        wb_write(2'd3, 32'd0);
        wait_idle(100);

        // overrun: one byte in the FSM, DEPTH queued, the rest dropped
        set_div(100);
        for (int i = 0; i < DEPTH + 2; i++) send_byte(8'(i * 7 + 3), i < DEPTH + 1);
        wb_read(2'd1, 32'h09);
        wb_write(2'd1, 32'h08);
        wb_read(2'd1, 32'h01);
        wait_idle(20000);
        wb_read(2'd1, 32'h02);

        // reset during data bit 3 of 0x00
        set_div(4);
        send_byte(8'h00, 1'b1);
        n = 0;
        while (tx !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        check("abort_frame_started", tx, 0);
        repeat (17) @(negedge clk);
        #2 rst = 1'b1;
        #1 check("tx_high_on_reset", tx, 1);
        check("ack_low_on_reset", ack, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0; tb_div = 434;
        wb_read(2'd1, 32'h02); wb_read(2'd2, 32'd434);
        lows = 0;
        repeat (100) begin @(negedge clk); if (tx !== 1'b1) lows++; end
        check("no_residual_tx", lows, 0);

`ifdef WB_UART_RX_EN
        set_div(8);
        send_rx(8'h3C, 1'b1, 8);
        wb_read(2'd1, 32'h06);
        wb_read(2'd0, 32'h3C);
        wb_read(2'd1, 32'h02);
        r = $urandom; b1 = r[7:0]; b2 = r[15:8];
        send_rx(b1, 1'b1, 8); send_rx(b2, 1'b1, 8);
        wb_read(2'd1, 32'h16);
        wb_read(2'd0, {24'd0, b2});
        wb_read(2'd1, 32'h12);
        wb_write(2'd1, 32'h10);
        wb_read(2'd1, 32'h02);
        send_rx(b1 ^ 8'hFF, 1'b0, 8);
        wb_read(2'd1, 32'h26);
        wb_read(2'd0, {24'd0, b1 ^ 8'hFF});
        wb_write(2'd1, 32'h20);
        wb_read(2'd1, 32'h02);
        rx = 1'b0; repeat (2) @(negedge clk); rx = 1'b1;
        repeat (120) @(negedge clk);
        wb_read(2'd1, 32'h02);
        wb_write(2'd3, 32'd2);
        send_rx(b2, 1'b1, 8);
        check("irq_rx", irq, 1);
        wb_read(2'd0, {24'd0, b2});
        repeat (2) @(negedge clk);
        check("irq_rx_clear", irq, 0);
        wb_write(2'd3, 32'd0);
`else
        repeat (60) begin @(negedge clk); r = $urandom; rx = r[0]; end
        rx = 1'b1;
        wb_write(2'd3, 32'd2);
        repeat (3) @(negedge clk);
        check("irq_no_rx", irq, 0);
        wb_write(2'd3, 32'd0);
        wb_write(2'd1, 32'h30);
        wb_read(2'd1, 32'h02);
        wb_read(2'd0, 32'd0);
`endif

        repeat (20) @(negedge clk);
        check("txq_drained", txq.size(), 0);
        check("rdq_drained", rd_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
